fetch_aligner: RTL

Instruction fetch front-end sitting between `instruction_mem` and `core`. Issues word-aligned fetches, buffers up to four halfwords, and presents one aligned instruction per handshake to the core, reassembling 32-bit instructions that straddle a word boundary when compressed (RVC) support is built in. Also handles control-flow redirects from the core: it flushes the buffer and discards any in-flight response.

---
 rtl/fetch_aligner.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_aligner.sv
// fetch_aligner: instruction fetch front-end between instruction memory and core.
// Issues word-aligned fetches, buffers up to four halfwords and hands the core
// one aligned instruction per handshake. Redirects flush the buffer and mark any
// in-flight response as stale.
// Build option: define FETCH_RVC_EN for compressed-instruction support
// (halfword pops, odd-halfword redirects, straddle reassembly). Without it every
// instruction is 32-bit and the PC steps by 4.
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_is_compressed
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [15:0] hw_q [4];
  logic [15:0] hw_d [4];
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic        skip_lo_q, skip_lo_d;

  logic        req_s;
  logic        push_s;
  logic        pop_s;
  logic [1:0]  push_n_s;
  logic [1:0]  pop_n_s;
  logic [1:0]  rd_ptr_p1_s;
  logic [1:0]  wr_ptr_p1_s;
  logic [15:0] head_lo_s;
  logic [15:0] head_hi_s;
  logic        head_comp_s;
  logic        valid_s;
  logic [31:0] redir_pc_s;
  logic        redir_skip_s;
  logic        unused_s;

`ifdef FETCH_RVC_EN
  assign head_comp_s  = (head_lo_s[1:0] != 2'b11);
  assign redir_pc_s   = {i_redirect_pc[31:1], 1'b0};
  assign redir_skip_s = i_redirect_pc[1];
  assign unused_s     = i_redirect_pc[0];
`else
  assign head_comp_s  = 1'b0;
  assign redir_pc_s   = {i_redirect_pc[31:2], 2'b00};
  assign redir_skip_s = 1'b0;
  assign unused_s     = ^i_redirect_pc[1:0];
`endif

  assign rd_ptr_p1_s = rd_ptr_q + 2'd1;
  assign wr_ptr_p1_s = wr_ptr_q + 2'd1;
  assign head_lo_s   = hw_q[rd_ptr_q];
  assign head_hi_s   = hw_q[rd_ptr_p1_s];

  // A compressed head needs one buffered halfword, a full instruction needs two.
  assign valid_s = head_comp_s ? (cnt_q >= 3'd1) : (cnt_q >= 3'd2);

  assign o_valid         = valid_s;
  assign o_is_compressed = valid_s & head_comp_s;
  assign o_instr         = !valid_s   ? 32'h0000_0000 :
                           head_comp_s ? {16'h0000, head_lo_s} : {head_hi_s, head_lo_s};
  assign o_pc            = pc_q;
  assign o_imem_addr     = fetch_addr_q;
  assign o_imem_req      = req_s;

  // Redirect outranks both push and pop; a response in WAIT is the only push source.
  assign push_s   = (state_q == ST_WAIT) && i_imem_valid && !i_redirect;
  assign pop_s    = valid_s && i_ready && !i_redirect;
  assign push_n_s = !push_s ? 2'd0 : (skip_lo_q ? 2'd1 : 2'd2);
  assign pop_n_s  = !pop_s  ? 2'd0 : (head_comp_s ? 2'd1 : 2'd2);

  // Fetch FSM state register.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch FSM next state; a redirect while a response is owed turns it stale.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (req_s) state_d = ST_WAIT;
        else       state_d = ST_RUN;
      end
      ST_WAIT: begin
        if (i_imem_valid)    state_d = ST_RUN;
        else if (i_redirect) state_d = ST_DROP;
        else                 state_d = ST_WAIT;
      end
      ST_DROP: begin
        if (i_imem_valid) state_d = ST_RUN;
        else              state_d = ST_DROP;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Fetch FSM output: request only with room for a full word and no redirect pending.
  always_comb begin
    req_s = 1'b0;
    if (i_resetn && !i_redirect && (state_q == ST_RUN) && (cnt_q <= 3'd2)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
  end

  // Buffer, PC and fetch-address next-state logic.
  always_comb begin
    hw_d         = hw_q;
    cnt_d        = cnt_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    skip_lo_d    = skip_lo_q;
    if (i_redirect) begin
      cnt_d        = 3'd0;
      rd_ptr_d     = 2'd0;
      wr_ptr_d     = 2'd0;
      pc_d         = redir_pc_s;
      fetch_addr_d = {i_redirect_pc[31:2], 2'b00};
      skip_lo_d    = redir_skip_s;
    end else begin
      if (push_s) begin
        if (skip_lo_q) begin
          hw_d[wr_ptr_q] = i_imem_rdata[31:16];
          skip_lo_d      = 1'b0;
        end else begin
          hw_d[wr_ptr_q]    = i_imem_rdata[15:0];
          hw_d[wr_ptr_p1_s] = i_imem_rdata[31:16];
        end
      end else begin
        hw_d = hw_q;
      end
      wr_ptr_d = wr_ptr_q + push_n_s;
      rd_ptr_d = rd_ptr_q + pop_n_s;
      pc_d     = pc_q + {29'd0, pop_n_s, 1'b0};
      cnt_d    = cnt_q + {1'b0, push_n_s} - {1'b0, pop_n_s};
      if (req_s) fetch_addr_d = fetch_addr_q + 32'd4;
      else       fetch_addr_d = fetch_addr_q;
    end
  end

  // Buffer, PC and fetch-address registers.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < 4; i++) hw_q[i] <= 16'h0000;
      cnt_q        <= 3'd0;
      rd_ptr_q     <= 2'd0;
      wr_ptr_q     <= 2'd0;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      skip_lo_q    <= 1'b0;
    end else begin
      hw_q         <= hw_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      skip_lo_q    <= skip_lo_d;
    end
  end

endmodule
